// File: rtl/ps2_interface.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_interface
//  Description : Receive-only PS/2 keyboard port. Synchronizes and de-glitches
//                the PS/2 lines, deframes 11-bit frames, strobes each good byte.
//                Define PS2_PARITY_CHECK_EN to reject frames with bad parity.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_interface #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       resetn,
    inout  wire        ps2_clock,
    inout  wire        ps2_data,
    output logic [7:0] ps2_key_data,
    output logic       ps2_key_pressed,
    output logic [7:0] ps2_out
);

    localparam int                  c_FILT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [c_FILT_W-1:0] c_FILT_LAST = c_FILT_W'(FILTER_LEN - 1);
    localparam int                  c_TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0]   c_TO_MAX    = c_TO_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DATA   = 2'd1;
    localparam logic [1:0] c_ST_PARITY = 2'd2;
    localparam logic [1:0] c_ST_STOP   = 2'd3;

    logic [1:0]          r_clk_sync;
    logic [1:0]          r_dat_sync;
    logic                r_filt_clk;
    logic [c_FILT_W-1:0] r_filt_cnt;
    logic [1:0]          r_state;
    logic [7:0]          r_shift;
    logic [2:0]          r_bit_cnt;
    logic                r_parity;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic [7:0]          r_key_data;
    logic                r_key_pressed;
    logic [7:0]          r_out;

    logic w_clk_s;
    logic w_dat_s;
    logic w_fall;
    logic w_parity_ok;

    assign w_clk_s = r_clk_sync[1];
    assign w_dat_s = r_dat_sync[1];

    // The fall is flagged in the same cycle the filtered clock commits to low.
    assign w_fall = r_filt_clk & ~w_clk_s & (r_filt_cnt == c_FILT_LAST);

`ifdef PS2_PARITY_CHECK_EN
    assign w_parity_ok = ^{r_shift, r_parity};
`else
    logic w_parity_unused;
    assign w_parity_unused = r_parity;
    assign w_parity_ok     = 1'b1;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clock};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
            if (w_clk_s == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == c_FILT_LAST) begin
                r_filt_clk <= w_clk_s;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= c_ST_IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_parity      <= 1'b0;
            r_to_cnt      <= '0;
            r_key_data    <= '0;
            r_key_pressed <= 1'b0;
            r_out         <= '0;
        end else begin
            r_key_pressed <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                case (r_state)
                    c_ST_IDLE: begin
                        if (!w_dat_s) begin
                            r_bit_cnt <= '0;
                            r_state   <= c_ST_DATA;
                        end
                    end
                    c_ST_DATA: begin
                        r_shift   <= {w_dat_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= c_ST_PARITY;
                        end
                    end
                    c_ST_PARITY: begin
                        r_parity <= w_dat_s;
                        r_state  <= c_ST_STOP;
                    end
                    default: begin
                        if (w_dat_s && w_parity_ok) begin
                            r_key_data    <= r_shift;
                            r_out         <= r_shift;
                            r_key_pressed <= 1'b1;
                        end
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end else if (r_state != c_ST_IDLE) begin
                // A stalled device leaves a partial frame; drop it silently.
                if (r_to_cnt == c_TO_MAX) begin
                    r_state   <= c_ST_IDLE;
                    r_to_cnt  <= '0;
                    r_bit_cnt <= '0;
                    r_shift   <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign ps2_key_data    = r_key_data;
    assign ps2_key_pressed = r_key_pressed;
    assign ps2_out         = r_out;

endmodule
`default_nettype wire

// File: tb/tb_ps2_interface.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_interface
//  Description : Directed bench for ps2_interface with a byte scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_interface;

    localparam int c_FILTER_LEN = 8;
    localparam int c_TIMEOUT    = 2000;
    // Bus half-period in system cycles, scaled down to keep the run short.
    localparam int c_HALF       = 40;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       r_clk_drv = 1'b1;
    logic       r_dat_drv = 1'b1;
    wire        w_ps2_clock;
    wire        w_ps2_data;
    logic [7:0] ps2_key_data;
    logic       ps2_key_pressed;
    logic [7:0] ps2_out;

    int         checks = 0;
    int         failures = 0;
    int         strobes = 0;
    int         exp_strobes = 0;
    logic [7:0] sb[$];

    assign w_ps2_clock = r_clk_drv;
    assign w_ps2_data  = r_dat_drv;

    always #10 clock = ~clock;

    ps2_interface #(
        .FILTER_LEN     (c_FILTER_LEN),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .clock           (clock),
        .resetn          (resetn),
        .ps2_clock       (w_ps2_clock),
        .ps2_data        (w_ps2_data),
        .ps2_key_data    (ps2_key_data),
        .ps2_key_pressed (ps2_key_pressed),
        .ps2_out         (ps2_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (ps2_key_pressed) begin
            logic [7:0] v_exp;
            strobes++;
            chk("strobe_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                v_exp = sb.pop_front();
                chk("key_data", 32'(ps2_key_data), 32'(v_exp));
                chk("ps2_out_at_strobe", 32'(ps2_out), 32'(v_exp));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic flip);
        return {1'b1, (~^b) ^ flip, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] frame, input int nbits, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            r_dat_drv = frame[i];
            cycles(c_HALF / 2);
            if (i == glitch_bit) begin
                r_clk_drv = 1'b0;
                cycles(3);
                r_clk_drv = 1'b1;
            end
            cycles(c_HALF / 2);
            r_clk_drv = 1'b0;
            cycles(c_HALF);
            r_clk_drv = 1'b1;
        end
        r_dat_drv = 1'b1;
        cycles(c_HALF);
    endtask

    task automatic expect_byte(input logic [7:0] b);
        sb.push_back(b);
        exp_strobes++;
    endtask

    task automatic idle_glitch(input logic dat);
        r_dat_drv = dat;
        cycles(10);
        r_clk_drv = 1'b0;
        cycles(3);
        r_clk_drv = 1'b1;
        cycles(20);
        r_dat_drv = 1'b1;
        cycles(10);
    endtask

    initial begin
        cycles(5);
        chk("reset_key_data", 32'(ps2_key_data), 32'h00);
        chk("reset_pressed", 32'(ps2_key_pressed), 32'h0);
        chk("reset_out", 32'(ps2_out), 32'h00);
        resetn = 1'b1;
        cycles(5);

        // Partial frame, then reset while the FSM is mid-frame.
        send_bits(make_frame(8'hA7, 1'b0), 5, -1);
        resetn = 1'b0;
        cycles(4);
        chk("midreset_out", 32'(ps2_out), 32'h00);
        chk("midreset_pressed", 32'(ps2_key_pressed), 32'h0);
        resetn = 1'b1;
        cycles(20);
        chk("post_reset_out", 32'(ps2_out), 32'h00);
        expect_byte(8'h5A);
        send_bits(make_frame(8'h5A, 1'b0), 11, -1);
        chk("after_reset_frame_out", 32'(ps2_out), 32'h5A);

        expect_byte(8'h1C);
        send_bits(make_frame(8'h1C, 1'b0), 11, -1);
        chk("good_frame_out_held", 32'(ps2_out), 32'h1C);
        chk("good_frame_strobes", 32'(strobes), 32'(exp_strobes));

        expect_byte(8'hF0);
        send_bits(make_frame(8'hF0, 1'b0), 11, -1);
        chk("break_prefix_out", 32'(ps2_out), 32'hF0);
        expect_byte(8'h1C);
        send_bits(make_frame(8'h1C, 1'b0), 11, -1);
        chk("break_code_out", 32'(ps2_out), 32'h1C);
        chk("break_strobes", 32'(strobes), 32'(exp_strobes));

        // Need a distinct held value so a wrongly accepted bad frame shows.
        expect_byte(8'h33);
        send_bits(make_frame(8'h33, 1'b0), 11, -1);
`ifdef PS2_PARITY_CHECK_EN
        send_bits(make_frame(8'h1C, 1'b1), 11, -1);
        chk("bad_parity_out", 32'(ps2_out), 32'h33);
`else
        expect_byte(8'h1C);
        send_bits(make_frame(8'h1C, 1'b1), 11, -1);
        chk("bad_parity_out", 32'(ps2_out), 32'h1C);
`endif
        chk("bad_parity_strobes", 32'(strobes), 32'(exp_strobes));

        send_bits(make_frame(8'hC5, 1'b0), 5, -1);
        cycles(c_TIMEOUT + 200);
        chk("abort_no_strobe", 32'(strobes), 32'(exp_strobes));
        expect_byte(8'h29);
        send_bits(make_frame(8'h29, 1'b0), 11, -1);
        chk("abort_next_out", 32'(ps2_out), 32'h29);

        idle_glitch(1'b1);
        idle_glitch(1'b0);
        idle_glitch(1'b1);
        chk("glitch_idle_strobes", 32'(strobes), 32'(exp_strobes));
        expect_byte(8'h1C);
        send_bits(make_frame(8'h1C, 1'b0), 11, 3);
        chk("glitch_frame_out", 32'(ps2_out), 32'h1C);

        cycles(20);
        chk("final_strobes", 32'(strobes), 32'(exp_strobes));
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
